// File: rtl/multiplicador_8bits_seq.sv
// rtl/multiplicador_8bits_seq.sv - sequential 8x8 unsigned shift-and-add multiplier controller
module multiplicador_8bits_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic [15:0] P,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [7:0]  m;
   logic [7:0]  acc;
   logic [7:0]  q;
   logic [2:0]  cnt;
   logic [8:0]  sum;

   // Shared 8-bit adder: partial high word plus multiplicand gated by the current multiplier bit
   always_comb begin
      sum = {1'b0, acc} + {1'b0, (q[0] ? m : 8'h00)};
   end

   // Control FSM and datapath registers; busy/done are registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         m     <= 8'h00;
         acc   <= 8'h00;
         q     <= 8'h00;
         cnt   <= 3'd0;
         P     <= 16'h0000;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  m     <= A;
                  q     <= B;
                  acc   <= 8'h00;
                  cnt   <= 3'd0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy <= 1'b0;
               end
            end
            RUN: begin
               // Carry out of the adder lands in acc[7]; low sum bit shifts into q
               acc <= sum[8:1];
               q   <= {sum[0], q[7:1]};
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  P     <= {sum[8:1], sum[0], q[7:1]};
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               // start is deliberately not sampled here; it is only seen after returning to IDLE
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
